// File: rtl/cache_pkg.sv
// Shared cache types and address-field width helpers, also used by the address decoder.
// Widths derive from capacity C, block size b, associativity N, address and word widths.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int byte_field_bits(input int word_bits);
        return $clog2(word_bits / 8);
    endfunction

    function automatic int word_field_bits(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int set_field_bits(input int word_capacity, input int words_per_block,
                                          input int way_count);
        return $clog2((word_capacity / words_per_block) / way_count);
    endfunction

    function automatic int tag_field_bits(input int addr_bits, input int word_capacity,
                                          input int words_per_block, input int way_count,
                                          input int word_bits);
        return addr_bits - set_field_bits(word_capacity, words_per_block, way_count)
                         - word_field_bits(words_per_block) - byte_field_bits(word_bits);
    endfunction

endpackage

// File: rtl/cache_block_addr_sequencer.sv
// Purpose: composes {tag,set,word,0} beat addresses across one cache block (CACHE_CRITICAL_WORD_FIRST_EN: start at start_word).
// Latency: first beat the cycle after start accept, one beat per accepted cycle, done one cycle after the last beat.
// Backpressure: mem_ready low stalls the beat with mem_addr/word_index/mem_last held; start_ready only while idle.
module cache_block_addr_sequencer
    import cache_pkg::*;
#(
    parameter int WORD_CAPACITY   = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WAY_COUNT       = 1,
    parameter int ADDR_BITS       = 32,
    parameter int WORD_BITS       = 32,
    localparam int BB = byte_field_bits(WORD_BITS),
    localparam int WB = word_field_bits(WORDS_PER_BLOCK),
    localparam int SB = set_field_bits(WORD_CAPACITY, WORDS_PER_BLOCK, WAY_COUNT),
    localparam int TB = tag_field_bits(ADDR_BITS, WORD_CAPACITY, WORDS_PER_BLOCK, WAY_COUNT, WORD_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [TB-1:0]        start_tag,
    input  logic [SB-1:0]        start_set,
    input  logic [WB-1:0]        start_word,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_last,
    output logic [WB-1:0]        word_index,
    output logic                 done
);

    state_t        state;
    logic [TB-1:0] tag_q;
    logic [SB-1:0] set_q;
    logic [WB-1:0] word_q;
    logic [WB-1:0] cnt_q;
    logic [WB-1:0] first_word;
    logic          last_beat;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign first_word = start_word;
`else
    logic unused_start_word;
    assign unused_start_word = ^start_word;
    assign first_word = '0;
`endif

    assign last_beat = (cnt_q == WB'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tag_q  <= '0;
            set_q  <= '0;
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        tag_q  <= start_tag;
                        set_q  <= start_set;
                        word_q <= first_word;
                        cnt_q  <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Word index wraps naturally within the block; the beat counter bounds the transfer.
                    if (mem_ready) begin
                        cnt_q  <= cnt_q + WB'(1);
                        word_q <= word_q + WB'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign mem_valid   = (state == ISSUE);
    assign done        = (state == DONE);
    assign mem_last    = (state == ISSUE) && last_beat;
    assign word_index  = word_q;
    assign mem_addr    = ADDR_BITS'({tag_q, set_q, word_q}) << BB;

endmodule

// File: tb/tb_cache_block_addr_sequencer.sv
// Scoreboard bench: driver pushes expected beats on start acceptance, monitor checks every cycle.
module tb_cache_block_addr_sequencer;

    localparam int TBW  = 27;
    localparam int SBW  = 1;
    localparam int WBW  = 2;
    localparam int WPB  = 4;
    localparam int SETS = 2;
    localparam int BPW  = 4;

    logic            clk;
    logic            reset;
    logic            start_valid;
    logic            start_ready;
    logic [TBW-1:0]  start_tag;
    logic [SBW-1:0]  start_set;
    logic [WBW-1:0]  start_word;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic            mem_last;
    logic [WBW-1:0]  word_index;
    logic            done;

    cache_block_addr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_tag   (start_tag),
        .start_set   (start_set),
        .start_word  (start_word),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_last    (mem_last),
        .word_index  (word_index),
        .done        (done)
    );

    typedef struct {
        logic [31:0] addr;
        int          widx;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    pend_done   = 0;
    bit    exp_done    = 0;
    bit    rand_ready  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte address = ((tag * sets + set) * words_per_block + word) * bytes_per_word
    function automatic logic [31:0] ref_addr(input longint tag, input longint set, input longint w);
        longint a;
        a = ((tag * SETS + set) * WPB + w) * BPW;
        return a[31:0];
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            beat_t b;
            exp_done  = pend_done;
            pend_done = 0;
            check("done", done, exp_done);
            check("mem_valid", mem_valid, exp_q.size() > 0);
            check("start_ready", start_ready, (exp_q.size() == 0) && !exp_done);
            if (mem_valid && exp_q.size() > 0) begin
                check("mem_addr", mem_addr, exp_q[0].addr);
                check("word_index", word_index, exp_q[0].widx);
                check("mem_last", mem_last, exp_q[0].last);
                if (mem_ready) begin
                    b = exp_q.pop_front();
                    if (b.last) pend_done = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic do_start(input logic [TBW-1:0] tag, input logic [SBW-1:0] set,
                            input logic [WBW-1:0] word);
        bit acc = 0;
        int w0;
        start_valid = 1'b1;
        start_tag   = tag;
        start_set   = set;
        start_word  = word;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        if (!acc) begin
            check("start_accept", 0, 1);
        end else begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            w0 = int'(word);
`else
            w0 = 0;
`endif
            for (int i = 0; i < WPB; i++) begin
                beat_t b;
                b.widx = (w0 + i) % WPB;
                b.addr = ref_addr(longint'(tag), longint'(set), longint'(b.widx));
                b.last = (i == WPB - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !pend_done && !exp_done) begin
                idle = 1;
                break;
            end
        end
        if (!idle) begin
            check("transfer_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp_q.delete();
        pend_done = 0;
        exp_done  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        start_tag   = '0;
        start_set   = '0;
        start_word  = '0;
        mem_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", start_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_done", done, 0);
        check("rst_mem_last", mem_last, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_word_index", word_index, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic refill; start_word only matters with critical-word-first
        do_start(27'hABC, 1'b1, 2'd2);
        wait_idle();

        // Beat 1 stalled for three cycles
        do_start(27'hABC, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        wait_idle();

        // New start offered while busy must be ignored
        do_start(27'hABC, 1'b1, 2'd1);
        start_valid = 1'b1;
        start_tag   = 27'h1;
        start_set   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_idle();

        // Abort at beat 2, then a fresh transfer
        do_start(27'hABC, 1'b1, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        repeat (2) @(posedge clk);
        #1;
        do_start(27'h0, 1'b0, 2'd3);
        wait_idle();

        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            logic [TBW-1:0] t;
            t = TBW'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_start(t, SBW'($urandom_range(0, 1)), WBW'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                pulse_reset();
            end
            wait_idle();
        end
        rand_ready = 0;
        #1;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
